// File: rtl/cmd_queue.sv
// cmd_queue: first-word-fall-through command FIFO between host/loader and issuer
// Ports: i_clk/i_rstn clock and async active-low reset; i_cmd/i_wr push side with o_full;
// i_rd pop side with o_cmd (head entry, zero when empty) and o_empty; i_flush discards all
// entries; o_count current occupancy.
// Build macro CMD_QUEUE_STATS_EN adds o_hwm (occupancy high-water mark), o_drop_cnt
// (saturating dropped pushes) and o_underrun_cnt (saturating pop-while-empty cycles).
package cmd_queue_pkg;
  typedef struct packed {
    logic [3:0]  opcode;
    logic [11:0] arg;
  } cmd_t;
endpackage

module cmd_queue #(
  parameter int DEPTH = 16,
  parameter int CMD_W = $bits(cmd_queue_pkg::cmd_t)
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic [CMD_W-1:0]         i_cmd,
  input  logic                     i_wr,
  output logic                     o_full,
  input  logic                     i_rd,
  output logic [CMD_W-1:0]         o_cmd,
  output logic                     o_empty,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count
`ifdef CMD_QUEUE_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   o_hwm,
  output logic [15:0]              o_drop_cnt,
  output logic [15:0]              o_underrun_cnt
`endif
);
  localparam int aw = $clog2(DEPTH);
  localparam logic [aw:0] full_cnt = (aw+1)'(DEPTH);
  logic [CMD_W-1:0] mem [DEPTH];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [aw:0] count, count_nxt;
  logic push, pop;
  assign o_full  = count == full_cnt;
  assign o_empty = count == '0;
  assign o_count = count;
  assign o_cmd   = o_empty ? '0 : mem[rd_ptr];
  assign push    = i_wr && !o_full;
  assign pop     = i_rd && !o_empty;
  always_comb begin
    count_nxt = push && !pop ? count + (aw+1)'(1) :
                pop && !push ? count - (aw+1)'(1) : count;
  end
  // Storage is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (push && !i_flush) mem[wr_ptr] <= i_cmd;
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + aw'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + aw'(1) : rd_ptr;
      count  <= count_nxt;
    end
  end
`ifdef CMD_QUEUE_STATS_EN
  // High-water mark tracks registered occupancy, so it lags o_count by one cycle.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_hwm          <= '0;
      o_drop_cnt     <= '0;
      o_underrun_cnt <= '0;
    end else begin
      o_hwm          <= count > o_hwm ? count : o_hwm;
      o_drop_cnt     <= i_wr && o_full && !i_flush && o_drop_cnt != '1 ? o_drop_cnt + 16'd1 : o_drop_cnt;
      o_underrun_cnt <= i_rd && o_empty && o_underrun_cnt != '1 ? o_underrun_cnt + 16'd1 : o_underrun_cnt;
    end
  end
`endif
endmodule

// File: doc/cmd_queue.md
CMD_QUEUE -- requirements
Module: cmd_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the number of command entries; DEPTH is a power of two and at least 2.
REQ-002 The block SHALL have parameter CMD_W, default $bits(cmd_t), giving the width of one command word.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports named i_clk and i_rstn.
REQ-004 Port i_clk SHALL be an input, 1 bit wide, used as the single rising-edge clock.
REQ-005 Port i_rstn SHALL be an input, 1 bit wide, used as the asynchronous active-low reset.
REQ-006 Port i_cmd SHALL be an input, CMD_W bits wide, carrying the command pushed by the host or loader.
REQ-007 Port i_wr SHALL be an input, 1 bit wide, requesting a push.
REQ-008 Port o_full SHALL be an output, 1 bit wide, asserted when the queue holds DEPTH entries.
REQ-009 Port i_rd SHALL be an input, 1 bit wide, requesting a pop; it connects to the issuer's o_rd_queue.
REQ-010 Port o_cmd SHALL be an output, CMD_W bits wide, carrying the head entry; it connects to the issuer's i_cmd.
REQ-011 Port o_empty SHALL be an output, 1 bit wide, asserted when the queue holds 0 entries; it connects to the issuer's i_empty_queue.
REQ-012 Port i_flush SHALL be an input, 1 bit wide, requesting that all entries be discarded synchronously.
REQ-013 Port o_count SHALL be an output, $clog2(DEPTH)+1 bits wide, giving the current occupancy.

Function
REQ-014 Storage SHALL be a DEPTH x CMD_W register array with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-015 The queue SHALL be first-word-fall-through: o_cmd shall equal the entry at the read pointer, combinationally, whenever o_empty=0.
REQ-016 o_cmd SHALL drive all zeros while o_empty=1.
REQ-017 A push SHALL be accepted on a rising edge when i_wr=1 and o_full=0; accepted data becomes visible no earlier than the next cycle.
REQ-018 A pop SHALL be accepted on a rising edge when i_rd=1 and o_empty=0, advancing the read pointer by one.
REQ-019 On a simultaneous accepted push and pop, o_count SHALL be unchanged and both pointers SHALL advance.
REQ-020 i_wr while o_full=1 SHALL be dropped, even with a simultaneous i_rd; full status is based on registered occupancy only.
REQ-021 i_rd while o_empty=1 SHALL be ignored; with a simultaneous i_wr, the write is accepted and o_empty deasserts in the next cycle.
REQ-022 o_full SHALL equal (o_count==DEPTH), and o_empty SHALL equal (o_count==0); both are derived from the registered count.
REQ-023 i_flush=1 SHALL clear both pointers and o_count at the next edge, overriding any i_wr or i_rd in the same cycle.

Reset
REQ-024 While i_rstn=0, the pointers and o_count SHALL be 0, o_empty SHALL be 1, o_full SHALL be 0, and o_cmd SHALL be 0, asynchronously.
REQ-025 The array contents SHALL NOT be reset; a reset mid-operation discards all entries.
REQ-026 Under CMD_QUEUE_STATS_EN, all statistics registers SHALL reset to 0.

Configuration
REQ-027 Macro CMD_QUEUE_STATS_EN, when defined, SHALL add output o_hwm, $clog2(DEPTH)+1 bits wide, holding the maximum o_count since reset; i_flush does not clear it.
REQ-028 Macro CMD_QUEUE_STATS_EN, when defined, SHALL add output o_drop_cnt, 16 bits wide, a saturating count of dropped pushes (i_wr=1 with o_full=1, excluding flush cycles).
REQ-029 Macro CMD_QUEUE_STATS_EN, when defined, SHALL add output o_underrun_cnt, 16 bits wide, a saturating count of cycles with i_rd=1 and o_empty=1.
REQ-030 When CMD_QUEUE_STATS_EN is undefined, these three ports and their logic SHALL be absent, and the functional behaviour SHALL be identical.

Verification
REQ-031 Reset check: after reset, push A=0x11 -> next cycle o_empty=0, o_cmd=0x11, o_count=1; pop -> o_empty=1, o_cmd=0.
REQ-032 Fill and wrap: with DEPTH=16, push 16 entries -> o_full=1; push a 17th -> dropped, o_drop_cnt=1; then pop 16 entries -> FIFO order preserved; repeat the test across pointer wrap.
REQ-033 Simultaneous push and pop at count=5 -> o_count stays 5 and order is preserved; push and pop while empty -> count becomes 1 and o_cmd shows the pushed word.
REQ-034 Flush at count=9 together with i_wr=1 -> o_count=0 and o_empty=1 next cycle, the write is discarded, and o_hwm=9 is retained.
REQ-035 Async reset asserted mid-stream at count=7 -> outputs take reset values immediately, without waiting for a clock edge.
REQ-036 Underrun: 3 cycles of i_rd=1 while empty -> o_underrun_cnt=3 and o_count remains 0.
